// File: rtl/store_commit_buffer_if.sv
// Dcache write channel of store_commit_buffer: valid/ready request plus a
// completion pulse per accepted request.
interface store_commit_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [DATA_W-1:0]   mem_req_data;
    logic [DATA_W/8-1:0] mem_req_be;
    logic                mem_rsp_valid;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_data, mem_req_be,
        input  mem_req_ready, mem_rsp_valid
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_be,
        output mem_req_ready, mem_rsp_valid
    );
endinterface

// File: rtl/store_commit_buffer.sv
// Post-retire store buffer: accepts up to IN_W stores per cycle, drains them in order
// to the dcache one outstanding write at a time. Load forwarding under STORE_BUF_FWD_EN.
module store_commit_buffer #(
    parameter int  DEPTH  = 8,
    parameter int  IN_W   = 2,
    parameter int  ADDR_W = 32,
    parameter int  DATA_W = 32,
    localparam int BE_W   = DATA_W / 8,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [IN_W-1:0]          ret_valid,
    input  logic [IN_W*ADDR_W-1:0]   ret_addr,
    input  logic [IN_W*DATA_W-1:0]   ret_data,
    input  logic [IN_W*BE_W-1:0]     ret_be,
    output logic [CNT_W-1:0]         free_slots,
    store_commit_buffer_if.master    mem,
    output logic                     empty,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    output logic [BE_W-1:0]          fwd_be
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int WA_W  = ADDR_W - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [WA_W-1:0]   addr_q [DEPTH];
    logic [WA_W-1:0]   addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [BE_W-1:0]   be_q   [DEPTH];
    logic [BE_W-1:0]   be_d   [DEPTH];

    logic              req_valid_q, req_valid_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic [BE_W-1:0]   req_be_q, req_be_d;

    logic [CNT_W-1:0]  enq_k;
    logic              enq_ok;
    logic              pop;
    logic [PTR_W-1:0]  head_nxt;
    logic              unused_bits;

    always_comb begin
        enq_k = '0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            enq_k = enq_k + CNT_W'(ret_valid[i]);
        end
    end

    assign free_slots = CNT_W'(DEPTH) - count_q;
    assign enq_ok     = (enq_k <= free_slots);
    assign head_nxt   = head_q + PTR_W'(1);
    assign empty      = (count_q == '0) && (state_q == S_IDLE);

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        data_d      = data_q;
        be_d        = be_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_be_d    = req_be_q;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d     = S_SEND;
                    req_valid_d = 1'b1;
                    req_addr_d  = {addr_q[head_q], 2'b00};
                    req_data_d  = data_q[head_q];
                    req_be_d    = be_q[head_q];
                end
            end
            S_SEND: begin
                if (mem.mem_req_ready) begin
                    state_d     = S_WAIT;
                    req_valid_d = 1'b0;
                    req_addr_d  = '0;
                    req_data_d  = '0;
                    req_be_d    = '0;
                end
            end
            S_WAIT: begin
                if (mem.mem_rsp_valid) begin
                    pop             = 1'b1;
                    valid_d[head_q] = 1'b0;
                    head_d          = head_nxt;
                    // Next entry is already resident, so skip the IDLE bubble
                    if (count_q > CNT_W'(1)) begin
                        state_d     = S_SEND;
                        req_valid_d = 1'b1;
                        req_addr_d  = {addr_q[head_nxt], 2'b00};
                        req_data_d  = data_q[head_nxt];
                        req_be_d    = be_q[head_nxt];
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An overflowing retire group is dropped whole rather than partially written
        if (enq_ok) begin
            for (int unsigned i = 0; i < IN_W; i++) begin
                if (ret_valid[i]) begin
                    valid_d[tail_q + PTR_W'(i)] = 1'b1;
                    addr_d[tail_q + PTR_W'(i)]  = ret_addr[i*ADDR_W+2 +: WA_W];
                    data_d[tail_q + PTR_W'(i)]  = ret_data[i*DATA_W +: DATA_W];
                    be_d[tail_q + PTR_W'(i)]    = ret_be[i*BE_W +: BE_W];
                end
            end
            tail_d = tail_q + PTR_W'(enq_k);
        end

        count_d = count_q + (enq_ok ? enq_k : '0) - CNT_W'(pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            addr_q      <= '{default: '0};
            data_q      <= '{default: '0};
            be_q        <= '{default: '0};
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            be_q        <= be_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_be_q    <= req_be_d;
        end
    end

    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_addr  = req_addr_q;
    assign mem.mem_req_data  = req_data_q;
    assign mem.mem_req_be    = req_be_q;

`ifdef STORE_BUF_FWD_EN
    // Scan oldest to youngest so the last match wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_be   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[head_q + PTR_W'(i)] &&
                (addr_q[head_q + PTR_W'(i)] == ld_addr[ADDR_W-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[head_q + PTR_W'(i)];
                fwd_be   = be_q[head_q + PTR_W'(i)];
            end
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
    assign fwd_be   = '0;
`endif

    always_comb begin
        unused_bits = 1'b0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            unused_bits = unused_bits ^ ret_addr[i*ADDR_W] ^ ret_addr[i*ADDR_W+1];
        end
`ifdef STORE_BUF_FWD_EN
        unused_bits = unused_bits ^ (^ld_addr[1:0]);
`else
        unused_bits = unused_bits ^ (^ld_addr);
`endif
    end

    a_enq_fits: assert property (@(posedge clock) disable iff (reset)
        enq_k <= free_slots);
    a_ret_contig: assert property (@(posedge clock) disable iff (reset)
        ((ret_valid + IN_W'(1)) & ret_valid) == '0);
    a_rsp_in_wait: assert property (@(posedge clock) disable iff (reset)
        mem.mem_rsp_valid |-> (state_q == S_WAIT));
endmodule
